// File: rtl/burst_pi_filter.sv
`default_nettype none
// ============================================================================
// Module      : burst_pi_filter
// Description : Colour-burst phase-error accumulator feeding a PI loop filter.
//               Each burst is summed (optionally averaged), then one PI update
//               produces a new NCO frequency offset. Lock is tracked from the
//               per-line error magnitude with an inactivity timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_pi_filter #(
    parameter int          ERR_W       = 12,
    parameter int          ACC_W       = 32,
    parameter int          CNT_W       = 7,
    parameter int          MIN_SAMPLES = 8,
    parameter int unsigned INT_LIM     = 2**24,
    parameter int          LOCK_LINES  = 16,
    parameter int          TIMEOUT     = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    burst_active,
    input  logic signed [ERR_W-1:0] error_in,
    input  logic        [4:0]       kp_shift,
    input  logic        [4:0]       ki_shift,
    input  logic                    avg_en,
    input  logic                    hold,
    input  logic        [ERR_W-1:0] lock_thresh,
    output logic signed [ACC_W-1:0] offset_out,
    output logic                    update_valid,
    output logic                    locked,
    output logic                    sat_flag
);

    localparam int LOG_W  = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int LOCK_W = $clog2(LOCK_LINES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_SAMPLES);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_LINES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    // Integrator clamp limits at the widened (ACC_W+1) compare width and at
    // the stored ACC_W width.
    localparam logic signed [ACC_W:0]   INT_POS_W = (ACC_W+1)'(INT_LIM);
    localparam logic signed [ACC_W:0]   INT_NEG_W = -INT_POS_W;
    localparam logic signed [ACC_W-1:0] INT_POS_A = ACC_W'(INT_LIM);
    localparam logic signed [ACC_W-1:0] INT_NEG_A = -INT_POS_A;

    // Saturate an ACC_W+1 signed sum back into ACC_W signed range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        logic signed [ACC_W-1:0] r;
        if (v[ACC_W] != v[ACC_W-1]) begin
            r = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic signed [ACC_W-1:0]  acc_q,     acc_d;
    logic        [CNT_W-1:0]  cnt_q,     cnt_d;
    logic signed [ACC_W-1:0]  cap_q,     cap_d;
    logic                     cap_vld_q, cap_vld_d;
    logic signed [ACC_W-1:0]  integ_q,   integ_d;
    logic signed [ACC_W-1:0]  offset_q,  offset_d;
    logic                     upd_q,     upd_d;
    logic        [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                     locked_q,  locked_d;
    logic        [TMO_W-1:0]  tmo_q,     tmo_d;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_err_ext;
    logic signed [ACC_W:0]   w_acc_sum;
    logic        [LOG_W-1:0] w_lg;
    logic signed [ACC_W-1:0] w_p_term;
    logic signed [ACC_W-1:0] w_i_term;
    logic signed [ACC_W:0]   w_off_sum;
    logic signed [ACC_W:0]   w_int_sum;
    logic        [ACC_W:0]   w_cap_abs;
    logic                    w_good_line;
    logic                    w_do_update;

    assign w_err_ext = {{(ACC_W-ERR_W){error_in[ERR_W-1]}}, error_in};
    assign w_acc_sum = {acc_q[ACC_W-1], acc_q} + {w_err_ext[ACC_W-1], w_err_ext};

    assign w_p_term  = cap_q >>> kp_shift;
    assign w_i_term  = integ_q >>> ki_shift;
    assign w_off_sum = {w_p_term[ACC_W-1], w_p_term} + {w_i_term[ACC_W-1], w_i_term};
    assign w_int_sum = {integ_q[ACC_W-1], integ_q} + {cap_q[ACC_W-1], cap_q};

    // Magnitude is taken one bit wider so the most negative value stays exact.
    assign w_cap_abs   = cap_q[ACC_W-1] ? -{cap_q[ACC_W-1], cap_q} : {cap_q[ACC_W-1], cap_q};
    assign w_good_line = (w_cap_abs <= (ACC_W+1)'(lock_thresh));
    assign w_do_update = cap_vld_q & ~hold;

    // floor(log2(sample count)) for burst averaging: highest set bit index.
    always_comb begin
        w_lg = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (cnt_q[i]) begin
                w_lg = LOG_W'(i);
            end
        end
    end

    // Burst accumulation and line-error capture at burst end.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        cap_vld_d = 1'b0;
        if (burst_active) begin
            // A full counter means the burst is over-long; extra samples are dropped.
            if (cnt_q != CNT_MAX) begin
                acc_d = sat_acc(w_acc_sum);
                cnt_d = cnt_q + 1'b1;
            end
        end else if (cnt_q != '0) begin
            acc_d = '0;
            cnt_d = '0;
            if (cnt_q >= MIN_CNT) begin
                cap_vld_d = 1'b1;
                cap_d     = avg_en ? (acc_q >>> w_lg) : acc_q;
            end
        end
    end

    // PI update, lock tracking and inactivity timeout.
    always_comb begin
        integ_d    = integ_q;
        offset_d   = offset_q;
        upd_d      = 1'b0;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        tmo_d      = tmo_q;
        if (w_do_update) begin
            offset_d = sat_acc(w_off_sum);
            upd_d    = 1'b1;
            tmo_d    = '0;
            if (w_int_sum > INT_POS_W) begin
                integ_d = INT_POS_A;
            end else if (w_int_sum < INT_NEG_W) begin
                integ_d = INT_NEG_A;
            end else begin
                integ_d = w_int_sum[ACC_W-1:0];
            end
            if (w_good_line) begin
                if (lock_cnt_q != LOCK_MAX) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
                locked_d = (lock_cnt_d == LOCK_MAX);
            end else begin
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end
        end else if (!hold) begin
            // Coasting (hold) freezes the timeout so a held loop keeps its lock.
            if (tmo_q >= TMO_LAST) begin
                tmo_d      = '0;
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // State register with asynchronous reset; reset also drops any pending update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            cap_q      <= '0;
            cap_vld_q  <= 1'b0;
            integ_q    <= '0;
            offset_q   <= '0;
            upd_q      <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            tmo_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            cap_vld_q  <= cap_vld_d;
            integ_q    <= integ_d;
            offset_q   <= offset_d;
            upd_q      <= upd_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            tmo_q      <= tmo_d;
        end
    end

    assign offset_out   = offset_q;
    assign update_valid = upd_q;
    assign locked       = locked_q;
    assign sat_flag     = (integ_q == INT_POS_A) || (integ_q == INT_NEG_A);

endmodule
`default_nettype wire

// File: tb/tb_burst_pi_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_pi_filter
// Description : Directed, table-driven bench for burst_pi_filter with
//               hand-written sequences for reset, back-to-back bursts, lock
//               and timeout behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_pi_filter;

    localparam int ERR_W       = 12;
    localparam int ACC_W       = 32;
    localparam int CNT_W       = 7;
    localparam int MIN_SAMPLES = 8;
    localparam int INT_LIM     = 5000;
    localparam int LOCK_LINES  = 16;
    localparam int TIMEOUT     = 300;

    logic                    clk;
    logic                    rst;
    logic                    burst_active;
    logic signed [ERR_W-1:0] error_in;
    logic        [4:0]       kp_shift;
    logic        [4:0]       ki_shift;
    logic                    avg_en;
    logic                    hold;
    logic        [ERR_W-1:0] lock_thresh;
    logic signed [ACC_W-1:0] offset_out;
    logic                    update_valid;
    logic                    locked;
    logic                    sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    burst_pi_filter #(
        .ERR_W(ERR_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .MIN_SAMPLES(MIN_SAMPLES),
        .INT_LIM(INT_LIM), .LOCK_LINES(LOCK_LINES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .burst_active(burst_active), .error_in(error_in),
        .kp_shift(kp_shift), .ki_shift(ki_shift), .avg_en(avg_en), .hold(hold),
        .lock_thresh(lock_thresh), .offset_out(offset_out),
        .update_valid(update_valid), .locked(locked), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int do_rst;
        int n;
        int err;
        int avg;
        int kp;
        int ki;
        int hold;
        int exp_upd;
        int exp_off;
        int exp_sat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one burst of n identical samples, then returns #1 after the
    // PI-update edge (two edges after the burst-end edge is sampled).
    task automatic run_burst(input int n, input int err, input int avg,
                             input int kp, input int ki, input int hld);
        @(negedge clk);
        avg_en       = avg[0];
        kp_shift     = 5'(kp);
        ki_shift     = 5'(ki);
        hold         = hld[0];
        error_in     = ERR_W'(err);
        burst_active = 1'b1;
        repeat (n) @(negedge clk);
        burst_active = 1'b0;
        error_in     = '0;
        @(posedge clk);
        #1 chk("upd_at_burst_end", int'(update_valid), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // {rst, n, err, avg, kp, ki, hold, exp_upd, exp_off, exp_sat}
        vecs[0]  = '{1,  20,    16, 0,  3,  7, 0, 1,    40, 0};
        vecs[1]  = '{1,  20,    16, 1,  3,  7, 0, 1,     2, 0};
        vecs[2]  = '{0,   5,    16, 0,  3,  7, 0, 0,     2, 0};
        vecs[3]  = '{0,   8,    -3, 0,  0,  0, 0, 1,    -4, 0};
        vecs[4]  = '{0, 130,    10, 1,  1,  2, 0, 1,     8, 0};
        vecs[5]  = '{0,  12,    -7, 1,  0,  0, 0, 1,     4, 0};
        vecs[6]  = '{0,  10,   100, 0,  0,  0, 1, 0,     4, 0};
        vecs[7]  = '{0,  10,   -50, 0, 31,  0, 0, 1,     3, 0};
        vecs[8]  = '{0,  10,  1000, 0, 20, 20, 0, 1,    -1, 1};
        vecs[9]  = '{0,  10,  1000, 0, 20, 20, 0, 1,     0, 1};
        vecs[10] = '{0,  10,  -100, 0,  0,  0, 0, 1,  4000, 0};
        vecs[11] = '{0,   8,     0, 0, 31,  1, 0, 1,  2000, 0};
        vecs[12] = '{0,   7,    50, 0,  0,  0, 0, 0,  2000, 0};

        rst = 1'b1; burst_active = 1'b0; error_in = '0; kp_shift = '0;
        ki_shift = '0; avg_en = 1'b0; hold = 1'b0; lock_thresh = ERR_W'(10);

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_offset", int'(offset_out), 0);
        chk("rst_upd", int'(update_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sat", int'(sat_flag), 0);
        rst = 1'b0;

        // Table-driven bursts
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_rst != 0) apply_reset();
            run_burst(vecs[i].n, vecs[i].err, vecs[i].avg, vecs[i].kp, vecs[i].ki, vecs[i].hold);
            chk($sformatf("v%0d_upd", i), int'(update_valid), vecs[i].exp_upd);
            chk($sformatf("v%0d_offset", i), int'(offset_out), vecs[i].exp_off);
            chk($sformatf("v%0d_sat", i), int'(sat_flag), vecs[i].exp_sat);
            @(posedge clk);
            #1 chk($sformatf("v%0d_upd_pulse_end", i), int'(update_valid), 0);
        end
        hold = 1'b0;

        // Reset asserted mid-burst: outputs clear at once, no update afterwards
        @(negedge clk);
        kp_shift = '0; ki_shift = '0; avg_en = 1'b0;
        error_in = ERR_W'(50); burst_active = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_offset", int'(offset_out), 0);
        chk("midrst_upd", int'(update_valid), 0);
        chk("midrst_sat", int'(sat_flag), 0);
        @(negedge clk);
        burst_active = 1'b0; error_in = '0; rst = 1'b0;
        begin
            int seen = 0;
            repeat (5) begin
                @(posedge clk);
                #1 if (update_valid) seen = 1;
            end
            chk("midrst_no_update", seen, 0);
        end

        // Reset between capture and PI update
        @(negedge clk);
        error_in = ERR_W'(50); burst_active = 1'b1;
        repeat (8) @(negedge clk);
        burst_active = 1'b0; error_in = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            repeat (5) begin
                @(posedge clk);
                #1 if (update_valid) seen = 1;
            end
            chk("caprst_no_update", seen, 0);
            chk("caprst_offset", int'(offset_out), 0);
        end

        // Back-to-back bursts: second starts the cycle after burst end
        apply_reset();
        @(negedge clk);
        kp_shift = '0; ki_shift = '0; avg_en = 1'b0; hold = 1'b0;
        error_in = ERR_W'(5); burst_active = 1'b1;
        repeat (8) @(negedge clk);
        burst_active = 1'b0; error_in = '0;
        @(posedge clk);
        @(negedge clk);
        burst_active = 1'b1; error_in = ERR_W'(2);
        @(posedge clk);
        #1;
        chk("b2b_first_upd", int'(update_valid), 1);
        chk("b2b_first_offset", int'(offset_out), 40);
        repeat (8) @(negedge clk);
        burst_active = 1'b0; error_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("b2b_second_upd", int'(update_valid), 1);
        chk("b2b_second_offset", int'(offset_out), 56);

        // Lock acquisition: e=8 per line, threshold 10
        apply_reset();
        for (int i = 1; i <= LOCK_LINES; i++) begin
            run_burst(8, 1, 0, 31, 31, 0);
            if (i == LOCK_LINES - 1) chk("lock_before_16", int'(locked), 0);
            if (i == LOCK_LINES)     chk("lock_at_16", int'(locked), 1);
            @(posedge clk);
        end
        // One bad line (e=16) drops lock
        run_burst(8, 2, 0, 31, 31, 0);
        chk("lock_bad_line", int'(locked), 0);
        @(posedge clk);
        for (int i = 1; i <= LOCK_LINES; i++) begin
            run_burst(8, 1, 0, 31, 31, 0);
        end
        chk("relock", int'(locked), 1);
        // Timeout: lock drops exactly TIMEOUT edges after the last update
        repeat (TIMEOUT - 1) @(posedge clk);
        #1 chk("timeout_not_yet", int'(locked), 1);
        @(posedge clk);
        #1 chk("timeout_drop", int'(locked), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/burst_pi_filter.md
BURST_PI_FILTER -- requirements
Module: burst_pi_filter

Interface
REQ-001 SHALL have parameter ERR_W, default 12, signed width of error_in.
REQ-002 SHALL have parameter ACC_W, default 32, width of burst accumulator, integrator and offset_out.
REQ-003 SHALL have parameter CNT_W, default 7, width of sample counter.
REQ-004 SHALL have parameter MIN_SAMPLES, default 8, minimum burst length accepted.
REQ-005 SHALL have parameter INT_LIM, default 2^24, integrator magnitude clamp (positive, < 2^(ACC_W-1)).
REQ-006 SHALL have parameter LOCK_LINES, default 16, consecutive good lines required for lock.
REQ-007 SHALL have parameter TIMEOUT, default 4096, cycles without an update before lock drops.
REQ-008 clk  in  1  clock; all state changes on rising edge.
REQ-009 rst  in  1  reset; asynchronous, active-high.
REQ-010 burst_active  in  1  high while colour burst samples are valid.
REQ-011 error_in  in  ERR_W signed  per-sample phase error.
REQ-012 kp_shift  in  5  proportional arithmetic right-shift amount.
REQ-013 ki_shift  in  5  integral arithmetic right-shift amount.
REQ-014 avg_en  in  1  1 = normalise burst sum by sample count, 0 = raw sum.
REQ-015 hold  in  1  1 = freeze loop state at updates (coast).
REQ-016 lock_thresh  in  ERR_W unsigned  max |line error| counted as good.
REQ-017 offset_out  out  ACC_W signed  NCO frequency offset.
REQ-018 update_valid  out  1  one-cycle pulse when offset_out takes a new value.
REQ-019 locked  out  1  loop lock indicator.
REQ-020 sat_flag  out  1  high while integrator equals +INT_LIM or -INT_LIM.

Function
REQ-021 SHALL, each cycle with burst_active=1, add sign-extended error_in to the accumulator using saturating add at the ACC_W signed limits, and increment the counter.
REQ-022 SHALL saturate the counter at 2^CNT_W-1; once saturated, further samples in that burst are ignored.
REQ-023 SHALL treat the first cycle with burst_active=0 and counter>0 as burst end; accumulator and counter clear at that edge.
REQ-024 SHALL discard a burst whose counter < MIN_SAMPLES at burst end: no update, lock counter unaffected.
REQ-025 SHALL, at an accepted burst end, register line error e = accumulator if avg_en=0, else accumulator arithmetically right-shifted by floor(log2(counter)).
REQ-026 SHALL, one edge after e is registered, perform the PI update unless hold=1.
REQ-027 PI update: offset_out = sat_ACC_W((e >>> kp_shift) + (integrator_old >>> ki_shift)); integrator = clamp(integrator_old + e, -INT_LIM, +INT_LIM).
REQ-028 SHALL assert update_valid for exactly the cycle after the PI update edge, i.e. 2 edges after the burst-end edge.
REQ-029 SHALL, when hold=1 at PI-update time, leave integrator, offset_out, lock counter and locked unchanged and not pulse update_valid.
REQ-030 SHALL, if burst_active rises on the cycle immediately after burst end, start the new accumulation from zero without disturbing the pending update.
REQ-031 SHALL, at each PI update, increment the lock counter (saturating at LOCK_LINES) if |e| <= lock_thresh, else clear it and deassert locked at the same edge.
REQ-032 SHALL assert locked at the edge the lock counter reaches LOCK_LINES.
REQ-033 SHALL clear the lock counter and locked when TIMEOUT cycles elapse with no PI update; the timeout counter restarts at every PI update and is frozen while hold=1.
REQ-034 shift amounts >= ACC_W SHALL yield 0 or -1 per sign (pure arithmetic shift).

Reset
REQ-035 SHALL, on rst, immediately clear accumulator, counter, captured error, integrator, lock and timeout counters, offset_out=0, update_valid=0, locked=0, sat_flag=0.
REQ-036 SHALL, if rst asserts mid-burst or between capture and update, abandon that burst with no update after release.

Verification
REQ-037 20-cycle burst, error_in=+16, avg_en=0, kp=3, ki=7, integrator 0 -> e=320, offset_out=40, integrator=320, update_valid pulse 2 edges after burst end.
REQ-038 Same burst with avg_en=1 -> e=320>>>4=20, offset_out=2.
REQ-039 Burst of 5 samples (MIN_SAMPLES=8) -> no update_valid, offset_out unchanged.
REQ-040 Repeated +1000-error lines with INT_LIM small -> integrator clamps at +INT_LIM, sat_flag=1; a -error line then clears sat_flag.
REQ-041 16 lines |e|<=lock_thresh -> locked rises on 16th update; one bad line -> locked falls; TIMEOUT idle cycles after relock -> locked falls.
REQ-042 hold=1 across a burst -> no update_valid, offset_out/integrator frozen; rst asserted mid-burst -> all outputs 0, no update after release.
